// File: rtl/tournament_selector.sv
// -----------------------------------------------------------------------------
// tournament_selector
//
// Tournament chooser for the branch predictor. Each PC-indexed table entry
// holds one saturating confidence counter per component predictor; a lookup
// returns, one cycle later, the prediction of the most confident predictor
// (lowest index wins ties). Resolved branches train the counters, but only
// when the component predictors disagreed with each other. After reset the
// table is swept to the counter midpoint, one entry per cycle, while
// init_busy is high.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   lookup_valid/pc/pred   lookup request and component predictions
//   choice_valid, choice, choice_sel   registered result of the lookup
//   update_valid/pc/pred/choice/outcome   resolved-branch training input
//   init_busy         table initialisation sweep in progress
//
// Optional feature (macro TOURNAMENT_SELECTOR_STATS_EN):
//   adds mispredict_count and update_count, 16-bit saturating statistics.
// -----------------------------------------------------------------------------
module tournament_selector #(
   parameter int NUM_PRED = 3,
   parameter int CTR_W    = 2,
   parameter int IDX_W    = 6,
   parameter int PC_W     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                lookup_valid,
   input  logic [PC_W-1:0]     lookup_pc,
   input  logic [NUM_PRED-1:0] lookup_pred,
   output logic                choice_valid,
   output logic                choice,
   output logic [2:0]          choice_sel,
   input  logic                update_valid,
   input  logic [PC_W-1:0]     update_pc,
   input  logic [NUM_PRED-1:0] update_pred,
   input  logic                update_choice,
   input  logic                update_outcome,
   output logic                init_busy
`ifdef TOURNAMENT_SELECTOR_STATS_EN
   ,
   output logic [15:0]         mispredict_count,
   output logic [15:0]         update_count
`endif
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_MID = CTR_W'(1 << (CTR_W - 1));
   localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

   typedef logic [NUM_PRED-1:0][CTR_W-1:0] entry_t;
   typedef enum logic {INIT, RUN} state_t;

   state_t             state;
   logic [IDX_W-1:0]   sweep;
   entry_t             ctr_table [ENTRIES];

   logic [IDX_W-1:0]   upd_idx;
   logic [IDX_W-1:0]   lk_idx;
   entry_t             upd_cur;
   entry_t             upd_next;
   entry_t             lk_entry;
   logic [NUM_PRED-1:0] agree_vec;
   logic               discriminate;
   logic               update_fire;
   logic [CTR_W-1:0]   best_val;
   logic [2:0]         best_sel;
   logic               best_choice;

   assign upd_idx = update_pc[IDX_W+1:2];
   assign lk_idx  = lookup_pc[IDX_W+1:2];

   // PC bits outside the index field (and update_choice when statistics are
   // compiled out) carry no information for this block.
`ifdef TOURNAMENT_SELECTOR_STATS_EN
   logic unused_bits;
   assign unused_bits = ^{lookup_pc[1:0], lookup_pc[PC_W-1:IDX_W+2],
                          update_pc[1:0], update_pc[PC_W-1:IDX_W+2]};
`else
   logic unused_bits;
   assign unused_bits = ^{lookup_pc[1:0], lookup_pc[PC_W-1:IDX_W+2],
                          update_pc[1:0], update_pc[PC_W-1:IDX_W+2],
                          update_choice};
`endif

   // Training rule: a counter moves toward confidence when its predictor was
   // right and away when wrong. If every predictor agreed (or every one was
   // wrong) the branch says nothing about relative quality, so the entry is
   // left alone. Saturation is at both ends, never wrapping.
   always_comb begin
      upd_cur      = ctr_table[upd_idx];
      upd_next     = upd_cur;
      agree_vec    = ~(update_pred ^ {NUM_PRED{update_outcome}});
      discriminate = (agree_vec != '0) && (agree_vec != '1);
      if (discriminate) begin
         for (int i = 0; i < NUM_PRED; i++) begin
            if (agree_vec[i]) begin
               if (upd_cur[i] != CTR_MAX) upd_next[i] = upd_cur[i] + CTR_ONE;
            end else begin
               if (upd_cur[i] != '0) upd_next[i] = upd_cur[i] - CTR_ONE;
            end
         end
      end
   end

   assign update_fire = (state == RUN) && update_valid && discriminate;

   // Lookup selection. A same-cycle update to the same entry is forwarded so
   // the lookup sees post-update confidence. Strict '>' keeps the lowest
   // index on ties.
   always_comb begin
      lk_entry    = (update_fire && (upd_idx == lk_idx)) ? upd_next : ctr_table[lk_idx];
      best_val    = lk_entry[0];
      best_sel    = '0;
      best_choice = lookup_pred[0];
      for (int i = 1; i < NUM_PRED; i++) begin
         if (lk_entry[i] > best_val) begin
            best_val    = lk_entry[i];
            best_sel    = 3'(i);
            best_choice = lookup_pred[i];
         end
      end
   end

   // Counter storage. The INIT sweep writes the midpoint into one entry per
   // cycle; in RUN the trained entry is written back. The table itself has no
   // reset: the sweep is what gives it a defined value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT) begin
            for (int i = 0; i < NUM_PRED; i++) ctr_table[sweep][i] <= CTR_MID;
         end else if (update_fire) begin
            ctr_table[upd_idx] <= upd_next;
         end
      end
   end

   // Control FSM with registered outputs. Reset restarts the sweep at entry 0
   // from any state; lookups and updates are dropped while sweeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= INIT;
         sweep        <= '0;
         init_busy    <= 1'b1;
         choice_valid <= 1'b0;
         choice       <= 1'b0;
         choice_sel   <= '0;
`ifdef TOURNAMENT_SELECTOR_STATS_EN
         update_count     <= '0;
         mispredict_count <= '0;
`endif
      end else begin
         case (state)
            INIT: begin
               choice_valid <= 1'b0;
               sweep        <= sweep + IDX_W'(1);
               if (&sweep) begin
                  state     <= RUN;
                  init_busy <= 1'b0;
               end
            end
            RUN: begin
               choice_valid <= lookup_valid;
               if (lookup_valid) begin
                  choice     <= best_choice;
                  choice_sel <= best_sel;
               end
`ifdef TOURNAMENT_SELECTOR_STATS_EN
               if (update_valid) begin
                  if (update_count != 16'hFFFF) update_count <= update_count + 16'd1;
                  if ((update_choice != update_outcome) && (mispredict_count != 16'hFFFF))
                     mispredict_count <= mispredict_count + 16'd1;
               end
`endif
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule
